// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-mode convolution with two line buffers and a 2-stage MAC pipeline
module conv3x3_stream #(
    parameter int In_W    = 8,
    parameter int Wt_W    = 8,
    parameter int Out_d_W = 32,
    parameter int IMG     = 28
) (
    input  logic                      iClk,
    input  logic                      iRsn,
    input  logic                      iInValid,
    input  logic [In_W-1:0]           iPixel,
    input  logic [9*Wt_W-1:0]         iWeight,
    input  logic signed [Out_d_W-1:0] iBias,
    output logic                      oOutValid,
    output logic signed [Out_d_W-1:0] oOutData,
    output logic                      oLastOut
);
    localparam int CW = $clog2(IMG);
    localparam int PW = In_W + Wt_W + 1;
    localparam int SW = PW + 4;
    localparam logic [CW-1:0] LAST = CW'(IMG - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    logic [CW-1:0]             col_q, row_q, col_d, row_d;
    logic [In_W-1:0]           buf0_q [IMG];
    logic [In_W-1:0]           buf1_q [IMG];
    logic [In_W-1:0]           win_q [9];
    logic [In_W-1:0]           win_d [9];
    logic signed [PW-1:0]      prod_q [9];
    logic signed [PW-1:0]      prod_d [9];
    logic signed [Out_d_W-1:0] bias_q;
    logic signed [SW-1:0]      sum;
    logic                      win_ok, frame_end, p_vld_q, p_last_q;

    always_comb begin
        frame_end = (col_q == LAST) && (row_q == LAST);
        win_ok    = (row_q >= TWO) && (col_q >= TWO);
        col_d     = (col_q == LAST) ? '0 : col_q + CW'(1);
        row_d     = (col_q != LAST) ? row_q : (row_q == LAST) ? '0 : row_q + CW'(1);
        for (int i = 0; i < 3; i++) begin
            win_d[i*3]   = win_q[i*3+1];
            win_d[i*3+1] = win_q[i*3+2];
        end
        win_d[2] = buf1_q[IMG-1];
        win_d[5] = buf0_q[IMG-1];
        win_d[8] = iPixel;
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = PW'($signed({1'b0, win_d[k]})) * PW'($signed(iWeight[k*Wt_W +: Wt_W]));
            sum       = sum + SW'(prod_q[k]);
        end
    end

    // Products and bias are captured at the accept edge, so a frame boundary never mixes kernels.
    always_ff @(posedge iClk) begin
        if (iInValid) begin
            buf0_q[0] <= iPixel;
            buf1_q[0] <= buf0_q[IMG-1];
            for (int k = 1; k < IMG; k++) begin
                buf0_q[k] <= buf0_q[k-1];
                buf1_q[k] <= buf1_q[k-1];
            end
            win_q  <= win_d;
            prod_q <= prod_d;
            bias_q <= iBias;
        end
    end

    always_ff @(posedge iClk or posedge iRsn) begin
        if (iRsn) begin
            col_q     <= '0;
            row_q     <= '0;
            p_vld_q   <= 1'b0;
            p_last_q  <= 1'b0;
            oOutValid <= 1'b0;
            oOutData  <= '0;
            oLastOut  <= 1'b0;
        end else begin
            if (iInValid) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            p_vld_q   <= iInValid && win_ok;
            p_last_q  <= iInValid && frame_end;
            oOutValid <= p_vld_q;
            oLastOut  <= p_last_q;
            if (p_vld_q) oOutData <= Out_d_W'(sum) + bias_q;
        end
    end
endmodule
